pc_fetch_unit: RTL

- Program-counter register and instruction-fetch sequencer sitting directly downstream of the one-hot PC-input mux.
- Registers the mux result (next_pc) into the PC and issues a handshaked instruction read to program memory at the PC.
- Latches the returned word into the instruction register (IR) and holds it for the controller.
- Feeds pc_plus1 and pc_branch (PC+1+sx(im8)) back to the PC mux as two of its data inputs.

---
 rtl/pc_fetch_unit_pkg.sv | 21 ++
 rtl/pc_fetch_unit_next_calc.sv | 21 ++
 rtl/pc_fetch_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared types and constants for the PC / fetch slice.
// Holds the fetch FSM state enum, PC-mux one-hot selects and default widths.
package pc_fetch_unit_pkg;

  localparam int unsigned K_DEF       = 9;
  localparam int unsigned W_DEF       = 16;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [3:0] SEL_RD   = 4'b1000;
  localparam logic [3:0] SEL_BR   = 4'b0100;
  localparam logic [3:0] SEL_ZERO = 4'b0010;
  localparam logic [3:0] SEL_INC  = 4'b0001;

endpackage

// File: rtl/pc_fetch_unit_next_calc.sv
// pc_next_calc: combinational PC+1 and PC+1+sx(im8), both modulo 2^K.
// Ports: pc_i (current PC), im8_i (branch imm), pc_plus1_o, pc_branch_o.
module pc_next_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned K = K_DEF
) (
  input  logic [K-1:0] pc_i,
  input  logic [7:0]   im8_i,
  output logic [K-1:0] pc_plus1_o,
  output logic [K-1:0] pc_branch_o
);

  logic [K-1:0] sx_imm;

  // Needs K > 8: the immediate is widened by replicating its sign bit.
  assign sx_imm      = {{(K-8){im8_i[7]}}, im8_i};
  assign pc_plus1_o  = pc_i + K'(1);
  assign pc_branch_o = pc_plus1_o + sx_imm;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register plus handshaked instruction fetch into the IR.
// Ports: clk, reset (async, active low), next_pc/load_pc (PC load),
//   fetch_start, im8, mem_ack/mem_rdata (memory reply), ir_consume;
//   outputs pc_out, pc_plus1, pc_branch, mem_req, mem_addr, ir_out,
//   ir_valid, fetch_err (sticky timeout).
// Option: define PC_AUTOINC_EN to step the PC on every IR capture.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned K       = K_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [K-1:0] next_pc,
  input  logic         load_pc,
  input  logic         fetch_start,
  input  logic [7:0]   im8,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  input  logic         ir_consume,
  output logic [K-1:0] pc_out,
  output logic [K-1:0] pc_plus1,
  output logic [K-1:0] pc_branch,
  output logic         mem_req,
  output logic [K-1:0] mem_addr,
  output logic [W-1:0] ir_out,
  output logic         ir_valid,
  output logic         fetch_err
);

  fetch_state_e state_q, state_d;
  logic [K-1:0] pc_q, pc_d;
  logic [W-1:0] ir_q, ir_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;
  logic         pend_q, pend_d;
  logic [K-1:0] pend_pc_q, pend_pc_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         capture;
  logic         leave;

  pc_next_calc #(.K(K)) u_next (
    .pc_i        (pc_q),
    .im8_i       (im8),
    .pc_plus1_o  (pc_plus1),
    .pc_branch_o (pc_branch)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    vld_d     = vld_q;
    err_d     = err_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    cnt_d     = cnt_q;
    mem_req   = 1'b0;
    capture   = 1'b0;
    leave     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load_pc) pc_d = next_pc;
        if (fetch_start) state_d = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          capture = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (mem_ack) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
          err_d   = 1'b1;
          leave   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (load_pc) pc_d = next_pc;
        if (ir_consume) begin
          vld_d   = 1'b0;
          state_d = fetch_start ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The address must not move under an outstanding request, so loads
    // seen in REQ/WAIT are parked and applied when the request ends.
    if (mem_req && load_pc) begin
      pend_d    = 1'b1;
      pend_pc_d = next_pc;
    end

    if (capture) begin
      ir_d  = mem_rdata;
      vld_d = 1'b1;
      leave = 1'b1;
    end

    if (leave) begin
      pend_d = 1'b0;
      cnt_d  = '0;
      if (load_pc) pc_d = next_pc;
      else if (pend_q) pc_d = pend_pc_q;
`ifdef PC_AUTOINC_EN
      else if (capture) pc_d = pc_plus1;
`endif
    end
  end

  assign pc_out    = pc_q;
  assign mem_addr  = pc_q;
  assign ir_out    = ir_q;
  assign ir_valid  = vld_q;
  assign fetch_err = err_q;

endmodule
